// File: rtl/alu_pkg.sv
// alu_pkg: sequencer state encoding and the opcode set understood by the external ALU
package alu_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LOAD_OP = 3'd3,
    EXEC    = 3'd4,
    CAPTURE = 3'd5,
    SHOW    = 3'd6
  } state_e;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MOD = 4'd9;
  localparam logic [3:0] OP_MAX = OP_MOD;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: synchronizes a raw button and emits one pulse per press
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic prev_q, armed_q, synced;
  assign synced  = sync_q[SYNC_STAGES-1];
  assign pulse_o = synced & ~prev_q & armed_q;
  // reset zeros in the chain are not real samples; only arm once a genuine low has arrived
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= (sync_q << 1) | SYNC_STAGES'(btn_i);
      fill_q  <= (fill_q << 1) | SYNC_STAGES'(1);
      prev_q  <= synced;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~synced);
    end
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: button-stepped loader of operands/opcode for an external ALU,
// capturing its result and counting completed operations
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         btn_next,
  input  logic         btn_clear,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_s,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic [2:0]   state_o,
  output logic         done,
  output logic         op_err,
  output logic [7:0]   op_count
);
  state_e state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, res_d;
  logic [3:0] s_q, s_d, flags_d, op_sw;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d, nxt, clr;
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_next (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_next), .pulse_o(nxt)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_clear), .pulse_o(clr)
  );
  assign op_sw = 4'(sw);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      s_d     = '0;
      res_d   = '0;
      flags_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = nxt ? LOAD_A : IDLE;
        LOAD_A:  if (nxt) begin a_d = sw; state_d = LOAD_B; end
        LOAD_B:  if (nxt) begin b_d = sw; state_d = LOAD_OP; end
        LOAD_OP: if (nxt) begin
          if (op_sw <= OP_MAX) begin
            s_d     = op_sw;
            err_d   = 1'b0;
            state_d = EXEC;
          end else err_d = 1'b1;
        end
        EXEC:    state_d = CAPTURE;
        CAPTURE: begin
          res_d   = alu_result;
          flags_d = alu_flags;
          cnt_d   = cnt_q + 8'd1;
          state_d = SHOW;
        end
        SHOW:    state_d = nxt ? LOAD_A : SHOW;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_s    = s_q;
  assign state_o  = state_q;
  assign done     = (state_q == SHOW);
  assign op_err   = err_q;
  assign op_count = cnt_q;
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, operand/result width matching the ALU it drives.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of button synchronizer flops.
REQ-003 SHALL have port clk  in  1  the single system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port sw  in  N  raw operand/opcode switches; sw[3:0] is the opcode when N>=4.
REQ-006 SHALL have port btn_next  in  1  raw, asynchronous, active-high step button.
REQ-007 SHALL have port btn_clear  in  1  raw, asynchronous, active-high abort button.
REQ-008 SHALL have ports alu_a, alu_b  out  N  registered operands driven to the ALU.
REQ-009 SHALL have port alu_s  out  4  registered opcode driven to the ALU.
REQ-010 SHALL have port alu_result  in  N  ALU result, combinational from alu_a/alu_b/alu_s.
REQ-011 SHALL have port alu_flags  in  4  ALU flags {of,cry,zr,neg}.
REQ-012 SHALL have port res_q  out  N  captured result.
REQ-013 SHALL have port flags_q  out  4  captured flags, same bit order as alu_flags.
REQ-014 SHALL have port state_o  out  3  current state encoding, for board LEDs.
REQ-015 SHALL have ports done  out  1 (high in SHOW) and op_err  out  1 (sticky invalid-opcode indicator).
REQ-016 SHALL have port op_count  out  8  number of completed operations.

Function
REQ-017 SHALL pass each button through SYNC_STAGES flops, then rising-edge detect it; one press equals exactly one step pulse.
REQ-018 SHALL implement states IDLE=0, LOAD_A=1, LOAD_B=2, LOAD_OP=3, EXEC=4, CAPTURE=5, SHOW=6.
REQ-019 SHALL move from IDLE to LOAD_A on a next pulse.
REQ-020 SHALL latch sw into alu_a on a next pulse in LOAD_A, then go to LOAD_B.
REQ-021 SHALL latch sw into alu_b on a next pulse in LOAD_B, then go to LOAD_OP.
REQ-022 SHALL handle a next pulse in LOAD_OP as follows:
- sw[3:0]<=9: latch into alu_s, clear op_err, go to EXEC.
- sw[3:0]>9: set op_err, leave alu_s unchanged, stay in LOAD_OP.
REQ-023 SHALL spend exactly one cycle in EXEC and then go to CAPTURE, giving the ALU one cycle of settling.
REQ-024 SHALL register alu_result into res_q and alu_flags into flags_q in CAPTURE, then go to SHOW; res_q is valid 2 cycles after the opcode-latching edge.
REQ-025 SHALL increment op_count on CAPTURE, wrapping 255->0.
REQ-026 SHALL hold done=1 in SHOW; a next pulse in SHOW returns to LOAD_A with operands retained.
REQ-027 SHALL return to IDLE from any state on a clear pulse, with:
- alu_a, alu_b, alu_s, res_q, flags_q, op_err zeroed;
- op_count preserved.
REQ-028 SHALL give clear priority over next when both pulses occur in the same cycle.
REQ-029 SHALL ignore next pulses in EXEC and CAPTURE.
REQ-030 SHALL keep alu_a, alu_b and alu_s stable outside their load cycles.

Reset
REQ-031 SHALL on rst_n low, asynchronously set state=IDLE and all outputs to 0, including op_count and the synchronizer flops.
REQ-032 SHALL after rst_n deassertion, ignore buttons already held high until they are released and pressed again.
REQ-033 SHALL on reset asserted during EXEC or CAPTURE, discard the capture: res_q stays 0 and op_count is not incremented.

Structure
REQ-034 SHALL place the state enum, the opcode constants (ADD=0 .. MOD=9) and OP_MAX=9 in shared package alu_pkg.
REQ-035 SHALL use one sub-module, btn_sync_edge (synchronizer plus rising-edge detector), instantiated twice.
REQ-036 SHALL contain no arithmetic beyond the op_count increment; all computation is done by the external ALU.

Verification
REQ-037 SHALL cover these directed scenarios:
- Reset, then sw=3 next, sw=5 next, sw=0 next -> alu_a=3, alu_b=5, alu_s=0; 2 cycles later res_q=8, flags_q neg=1 and of=1, done=1, op_count=1.
- In LOAD_OP, sw=4'hC next -> op_err=1, state_o=3, alu_s unchanged; then sw=2 next -> op_err=0, state_o=4.
- next and clear pulsed in the same cycle in LOAD_B -> state_o=0, alu_a=0.
- next held high for 100 cycles -> exactly one state advance.
- 256 completed operations -> op_count=0.
- rst_n low for 1 cycle during EXEC -> all outputs 0, state_o=0 immediately, with no clock edge required.
